spi_slave_port: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 9 +
 rtl/spi_slave_port_if.sv | 13 +
 rtl/spi_slave_port_sync_edge.sv | 33 +++
 rtl/spi_slave_port.sv | 136 +++++++++++++
 tb/tb_spi_slave_port.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared status bit positions and default idle fill byte
// Used by spi_slave_port and its testbench.
package spi_slave_pkg;
    localparam int ST_RX_FULL  = 7;
    localparam int ST_TX_EMPTY = 6;
    localparam int ST_OVERRUN  = 5;
    localparam int ST_ACTIVE   = 4;
    localparam logic [7:0] DEF_IDLE_FILL = 8'hFF;
endpackage

// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: CPU I/O bus between the Z80 I/O decoder and the SPI port
// din/wr_data: byte and strobe to load the TX holding register
// rd_data/rd_status: read levels; dout/oe_n: read data and its valid (low)
interface spi_slave_port_if;
    logic [7:0] din;
    logic       wr_data;
    logic       rd_data;
    logic       rd_status;
    logic [7:0] dout;
    logic       oe_n;
    modport master (output din, wr_data, rd_data, rd_status, input dout, oe_n);
    modport slave  (input din, wr_data, rd_data, rd_status, output dout, oe_n);
endinterface

// File: rtl/spi_slave_port_sync_edge.sv
// sync_edge: 2-FF synchronizer with registered one-clk rise/fall pulses
// d_i: asynchronous input; q_o: synchronized level; rise_o/fall_o: edge pulses
// RST_VAL: level the chain resets to, so reset never produces a false edge.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q, rise_q, fall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            s3_q   <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end
    assign q_o    = s2_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 responder exchanging bytes with the Z80 I/O bus
// clk/rst_n: system clock, async active-low reset
// bus: CPU side (TX holding write, RX/status read)
// spi_sclk/spi_cs_n/spi_mosi: async external master lines
// spi_miso/spi_miso_oe: slave data out and its drive enable
module spi_slave_port
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] IDLE_FILL = DEF_IDLE_FILL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_slave_port_if.slave        bus,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(spi_sclk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
        .q_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
        .q_o(mosi), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d, rx_reg_q, rx_reg_d;
    logic [7:0] hold_q, hold_d, tx_sh_q, tx_sh_d;
    logic       rx_full_q, rx_full_d, ovr_q, ovr_d, tx_empty_q, tx_empty_d;
    logic       rd_prev_q, rd_fall, load;
    logic [7:0] status;

    assign rd_fall = rd_prev_q & ~bus.rd_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_reg_d   = rx_reg_q;
        hold_d     = hold_q;
        tx_sh_d    = tx_sh_q;
        tx_empty_d = tx_empty_q;
        // A read completing this cycle frees the RX register before any new byte lands.
        rx_full_d  = rx_full_q & ~rd_fall;
        ovr_d      = ovr_q & ~rd_fall;
        load       = 1'b0;
        if (cs_fall) begin
            state_d = ACTIVE;
            cnt_d   = 3'd0;
            load    = 1'b1;
        end else if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else if (state_q == ACTIVE) begin
            if (sclk_rise) begin
                rx_sh_d = {rx_sh_q[6:0], mosi};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    if (rx_full_d) begin
                        ovr_d = 1'b1;
                    end else begin
                        rx_reg_d  = rx_sh_d;
                        rx_full_d = 1'b1;
                    end
                end
            end
            if (sclk_fall) begin
                if (cnt_q == 3'd0) load = 1'b1;
                else tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
        end
        // Shifter load uses the old holding value; a same-cycle write lands after it.
        if (load) begin
            tx_sh_d    = tx_empty_q ? IDLE_FILL : hold_q;
            tx_empty_d = 1'b1;
        end
        if (bus.wr_data) begin
            hold_d     = bus.din;
            tx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_reg_q   <= 8'h00;
            hold_q     <= 8'h00;
            tx_sh_q    <= IDLE_FILL;
            rx_full_q  <= 1'b0;
            ovr_q      <= 1'b0;
            tx_empty_q <= 1'b1;
            rd_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_reg_q   <= rx_reg_d;
            hold_q     <= hold_d;
            tx_sh_q    <= tx_sh_d;
            rx_full_q  <= rx_full_d;
            ovr_q      <= ovr_d;
            tx_empty_q <= tx_empty_d;
            rd_prev_q  <= bus.rd_data;
        end
    end

    always_comb begin
        status              = 8'h00;
        status[ST_RX_FULL]  = rx_full_q;
        status[ST_TX_EMPTY] = tx_empty_q;
        status[ST_OVERRUN]  = ovr_q;
        status[ST_ACTIVE]   = state_q == ACTIVE;
    end

    assign bus.dout    = bus.rd_data ? rx_reg_q : bus.rd_status ? status : 8'h00;
    assign bus.oe_n    = ~(bus.rd_data | bus.rd_status);
    assign spi_miso    = tx_sh_q[7];
    assign spi_miso_oe = state_q == ACTIVE;
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed self-checking bench for spi_slave_port
module tb_spi_slave_port;
    logic clk = 1'b0;
    logic rst_n, sclk, cs_n, mosi, miso, miso_oe;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    spi_slave_port_if bus ();

    spi_slave_port #(.IDLE_FILL(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic get_status(output logic [7:0] s);
        bus.rd_status = 1'b1;
        #1 s = bus.dout;
        bus.rd_status = 1'b0;
    endtask

    task automatic do_read(output logic [7:0] d);
        bus.rd_data = 1'b1;
        #1 d = bus.dout;
        tick(1);
        bus.rd_data = 1'b0;
        tick(2);
    endtask

    task automatic cpu_write(input logic [7:0] v);
        bus.din = v;
        bus.wr_data = 1'b1;
        tick(1);
        bus.wr_data = 1'b0;
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            tick(6);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            tick(6);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start;
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_end;
        tick(6);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic test_reset;
        logic [7:0] s;
        tot_cnt++; if (miso !== 1'b1) $display("FAIL rst_miso got %b exp 1", miso); else pass_cnt++;
        tot_cnt++; if (miso_oe !== 1'b0) $display("FAIL rst_miso_oe got %b exp 0", miso_oe); else pass_cnt++;
        tot_cnt++; if (bus.dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", bus.dout); else pass_cnt++;
        tot_cnt++; if (bus.oe_n !== 1'b1) $display("FAIL rst_oe_n got %b exp 1", bus.oe_n); else pass_cnt++;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL rst_status got %h exp 40", s); else pass_cnt++;
    endtask

    task automatic test_idle_fill;
        logic [7:0] r, s;
        cs_start;
        tot_cnt++; if (miso_oe !== 1'b1) $display("FAIL idle_miso_oe got %b exp 1", miso_oe); else pass_cnt++;
        xfer_bits(8'hA5, 8, r);
        cs_end;
        tot_cnt++; if (r !== 8'hFF) $display("FAIL idle_miso_byte got %h exp ff", r); else pass_cnt++;
        get_status(s);
        tot_cnt++; if (s !== 8'hC0) $display("FAIL idle_status got %h exp c0", s); else pass_cnt++;
        bus.rd_data = 1'b1;
        #1;
        tot_cnt++; if (bus.oe_n !== 1'b0) $display("FAIL idle_oe_n got %b exp 0", bus.oe_n); else pass_cnt++;
        bus.rd_data = 1'b0;
        tick(1);
        do_read(r);
        tot_cnt++; if (r !== 8'hA5) $display("FAIL idle_rx got %h exp a5", r); else pass_cnt++;
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL idle_status_after_read got %h exp 40", s); else pass_cnt++;
    endtask

    task automatic test_tx;
        logic [7:0] r, s;
        cpu_write(8'h3C);
        get_status(s);
        tot_cnt++; if (s !== 8'h00) $display("FAIL tx_status_loaded got %h exp 00", s); else pass_cnt++;
        cs_n = 1'b0;
        tick(4);
        get_status(s);
        tot_cnt++; if (s !== 8'h50) $display("FAIL tx_status_after_cs got %h exp 50", s); else pass_cnt++;
        tot_cnt++; if (miso !== 1'b0) $display("FAIL tx_first_bit got %b exp 0", miso); else pass_cnt++;
        tick(2);
        xfer_bits(8'h00, 8, r);
        cs_end;
        tot_cnt++; if (r !== 8'h3C) $display("FAIL tx_byte got %h exp 3c", r); else pass_cnt++;
        do_read(r);
        tot_cnt++; if (r !== 8'h00) $display("FAIL tx_rx got %h exp 00", r); else pass_cnt++;
    endtask

    task automatic test_overrun;
        logic [7:0] r1, r2, s;
        cs_start;
        xfer_bits(8'h11, 8, r1);
        xfer_bits(8'h22, 8, r2);
        cs_end;
        tot_cnt++; if (r2 !== 8'hFF) $display("FAIL ovr_second_miso got %h exp ff", r2); else pass_cnt++;
        get_status(s);
        tot_cnt++; if (s !== 8'hE0) $display("FAIL ovr_status got %h exp e0", s); else pass_cnt++;
        do_read(r1);
        tot_cnt++; if (r1 !== 8'h11) $display("FAIL ovr_rx got %h exp 11", r1); else pass_cnt++;
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL ovr_status_cleared got %h exp 40", s); else pass_cnt++;
    endtask

    task automatic test_partial;
        logic [7:0] r, s;
        cs_start;
        xfer_bits(8'hF0, 5, r);
        cs_end;
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL part_status got %h exp 40", s); else pass_cnt++;
        cs_start;
        xfer_bits(8'h5A, 8, r);
        cs_end;
        get_status(s);
        tot_cnt++; if (s !== 8'hC0) $display("FAIL part_status_full got %h exp c0", s); else pass_cnt++;
        do_read(r);
        tot_cnt++; if (r !== 8'h5A) $display("FAIL part_rx got %h exp 5a", r); else pass_cnt++;
    endtask

    task automatic test_rd_same_cycle;
        logic [7:0] r, s;
        cs_start;
        xfer_bits(8'h77, 8, r);
        xfer_bits(8'h99, 7, r);
        mosi = 1'b1;
        tick(6);
        sclk = 1'b1;
        bus.rd_data = 1'b1;
        #1;
        tot_cnt++; if (bus.dout !== 8'h77) $display("FAIL same_old_rx got %h exp 77", bus.dout); else pass_cnt++;
        tick(3);
        bus.rd_data = 1'b0;
        tick(1);
        get_status(s);
        tot_cnt++; if (s !== 8'hD0) $display("FAIL same_status got %h exp d0", s); else pass_cnt++;
        tick(2);
        sclk = 1'b0;
        cs_end;
        do_read(r);
        tot_cnt++; if (r !== 8'h99) $display("FAIL same_new_rx got %h exp 99", r); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] r, s;
        cpu_write(8'h81);
        cs_start;
        xfer_bits(8'hFF, 4, r);
        #3 rst_n = 1'b0;
        #1;
        tot_cnt++; if (miso !== 1'b1) $display("FAIL rmid_miso got %b exp 1", miso); else pass_cnt++;
        tot_cnt++; if (miso_oe !== 1'b0) $display("FAIL rmid_miso_oe got %b exp 0", miso_oe); else pass_cnt++;
        tot_cnt++; if (bus.oe_n !== 1'b1) $display("FAIL rmid_oe_n got %b exp 1", bus.oe_n); else pass_cnt++;
        cs_n = 1'b1;
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL rmid_status got %h exp 40", s); else pass_cnt++;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        cs_start;
        xfer_bits(8'hC3, 8, r);
        cs_end;
        tot_cnt++; if (r !== 8'hFF) $display("FAIL rmid_miso_byte got %h exp ff", r); else pass_cnt++;
        do_read(r);
        tot_cnt++; if (r !== 8'hC3) $display("FAIL rmid_rx got %h exp c3", r); else pass_cnt++;
        get_status(s);
        tot_cnt++; if (s !== 8'h40) $display("FAIL rmid_status_end got %h exp 40", s); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        bus.din = 8'h00;
        bus.wr_data = 1'b0;
        bus.rd_data = 1'b0;
        bus.rd_status = 1'b0;
        tick(1);
        test_reset;
        test_idle_fill;
        test_tx;
        test_overrun;
        test_partial;
        test_rd_same_cycle;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
